// File: rtl/lc4_decode_dx.sv
// lc4_decode_dx: LC4 decode/register-read stage with regfile, load-use hazard detect and D->X register
module lc4_decode_dx #(
  parameter logic [15:0] RESET_PC = 16'h8200,
  parameter logic [15:0] NOP_INSN = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gwe,
  input  logic [15:0] i_d_insn,
  input  logic [15:0] i_d_pc,
  input  logic        i_flush,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_rd,
  input  logic [15:0] i_wb_data,
  output logic        o_stall,
  output logic [15:0] o_x_insn,
  output logic [15:0] o_x_pc,
  output logic [15:0] o_x_r1data,
  output logic [15:0] o_x_r2data,
  output logic [2:0]  o_x_rd,
  output logic        o_x_we,
  output logic        o_x_is_load
);
  logic [15:0] regs [8];
  logic [3:0]  op;
  logic [2:0]  rs, rt, rd;
  logic        rs_used, rt_used, we, is_load, bubble;
  logic [15:0] r1, r2;
  always_comb begin
    op      = i_d_insn[15:12];
    rs      = (op == 4'h2 || op == 4'hD) ? i_d_insn[11:9] : (op == 4'h8) ? 3'd7 : i_d_insn[8:6];
    rt      = (op == 4'h7) ? i_d_insn[11:9] : i_d_insn[2:0];
    rs_used = op == 4'h1 || op == 4'h2 || op == 4'h5 || op == 4'h6 || op == 4'h7 || op == 4'h8 ||
              op == 4'hA || op == 4'hD || (op == 4'h4 && !i_d_insn[11]) || i_d_insn[15:11] == 5'b11000;
    rt_used = ((op == 4'h1 || op == 4'h5) && !i_d_insn[5]) || (op == 4'h2 && !i_d_insn[8]) ||
              op == 4'h7 || (op == 4'hA && i_d_insn[5:4] == 2'b11);
    we      = op == 4'h1 || op == 4'h5 || op == 4'h6 || op == 4'h9 || op == 4'hA || op == 4'hD ||
              op == 4'h4 || op == 4'hF;
    rd      = (op == 4'h4 || op == 4'hF) ? 3'd7 : we ? i_d_insn[11:9] : 3'd0;
    is_load = op == 4'h6;
    r1      = (i_wb_we && i_wb_rd == rs) ? i_wb_data : regs[rs];
    r2      = (i_wb_we && i_wb_rd == rt) ? i_wb_data : regs[rt];
    // STR's data operand comes from a later bypass, so only its base register can stall
    o_stall = o_x_is_load && ((rs_used && rs == o_x_rd) || (rt_used && rt == o_x_rd && op != 4'h7));
    bubble  = i_flush || o_stall;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs        <= '{default: '0};
      o_x_insn    <= NOP_INSN;
      o_x_pc      <= RESET_PC;
      o_x_r1data  <= '0;
      o_x_r2data  <= '0;
      o_x_rd      <= '0;
      o_x_we      <= 1'b0;
      o_x_is_load <= 1'b0;
    end else if (gwe) begin
      if (i_wb_we) regs[i_wb_rd] <= i_wb_data;
      o_x_insn    <= bubble ? NOP_INSN : i_d_insn;
      o_x_pc      <= i_d_pc;
      o_x_r1data  <= bubble ? 16'h0 : r1;
      o_x_r2data  <= bubble ? 16'h0 : r2;
      o_x_rd      <= bubble ? 3'd0 : rd;
      o_x_we      <= !bubble && we;
      o_x_is_load <= !bubble && is_load;
    end
  end
endmodule
